mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported data memory between the pipeline MEM stage and a program loader/debug port. It sequences each access through a small FSM with a configurable read latency, and stalls the whole pipeline while a MEM-stage access is pending or the loader owns the memory. A starvation counter guarantees the loader forward progress.

## Interface
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles after the issue cycle (≥1)
- STARVE_MAX, 4, consecutive lost arbitrations after which the loader wins (≥1)

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous, active-low reset
- PipeReq  in  1  MEM stage access request (MemRead|MemWrite)
- PipeWe  in  1  1 = write
- PipeAddr  in  ADDR_W  address
- PipeWData  in  DATA_W  store data
- PipeRData  out  DATA_W  load data, valid when PipeStall falls
- PipeStall  out  1  freeze PC and all pipeline registers
- LdReq  in  1  loader request, held until LdGnt
- LdWe  in  1  1 = write
- LdAddr  in  ADDR_W  address
- LdWData  in  DATA_W  write data
- LdGnt  out  1  one-cycle accept pulse
- LdRData  out  DATA_W  read data
- LdRValid  out  1  one-cycle read-data strobe
- MemEn  out  1  memory access strobe
- MemWe  out  1  memory write enable
- MemAddr  out  ADDR_W  memory address
- MemWData  out  DATA_W  memory write data
- MemRData  in  DATA_W  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, DONE. At most one transaction is outstanding.
- IDLE:
  - Pick a winner and latch its we/addr/wdata/owner, then go to ISSUE.
  - With no request, stay in IDLE.
- Arbitration:
  - Pipe wins by default.
  - Loader wins if only LdReq is high, or if both request and starve_cnt == STARVE_MAX.
  - LdGnt = 1 in the IDLE cycle the loader wins.
- starve_cnt:
  - +1, saturating at STARVE_MAX, on each IDLE cycle where both request and pipe wins.
  - Cleared on a loader grant.
- ISSUE (one cycle):
  - MemEn = 1 and MemWe = latched we.
  - Write → DONE; read → WAIT.
- WAIT:
  - Lasts MEM_LAT cycles using a down-counter.
  - MemRData is captured into the read register at the edge ending the last WAIT cycle, then go to DONE.
- DONE (one cycle):
  - Pipe owner: PipeStall = 0.
  - Loader read: LdRValid = 1.
  - Always return to IDLE.
- Output equations:
  - PipeStall = PipeReq & !(state==DONE & owner==PIPE).
  - It is combinational, so it is also high while the loader owns the memory.
- Data outputs:
  - PipeRData and LdRData both show the read register.
  - It holds its value until the next read capture.
  - MemAddr/MemWData show the latched values in all states.
- Simultaneous events:
  - LdReq arriving during a pipe transaction waits until IDLE.
  - In the IDLE cycle right after DONE, a PipeReq belongs to the next instruction and is arbitrated fresh.
- Reset (Rst low, any time):
  - State IDLE, starve_cnt 0, all latched and read registers 0.
  - In-flight read is discarded and no LdRValid is produced.
- Reset values of outputs:
  - LdGnt = LdRValid = MemEn = MemWe = 0.
  - PipeStall = PipeReq.

## Timing
- Pipe read, request at cycle 0:
  - ISSUE c1, WAIT c2..c(1+MEM_LAT), DONE c(2+MEM_LAT).
  - Stall cycles 0..(1+MEM_LAT); with MEM_LAT=2 that is 4 stall cycles.
- Pipe write: ISSUE c1, DONE c2; stall in c0 and c1.
- Loader read: LdGnt c0, LdRValid c(2+MEM_LAT). Loader write: LdGnt c0, MemWe c1.
- Back-to-back requests: one transaction every 3 cycles (write) or 3+MEM_LAT cycles (read).

## Structure
- Package mem_arb_pkg holds:
  - the state enum
  - the OWNER_PIPE/OWNER_LD constants
  - default MEM_LAT/STARVE_MAX localparams.
- One sub-module, mem_arb_starve_ctr: saturating counter with inc/clr and a `hit` output (cnt == STARVE_MAX).
- The FSM, latches and read register live in the top module.

## Test plan
- Pipe lw to addr 0x10, memory returns 0xDEADBEEF, MEM_LAT=2:
  - PipeStall high for 4 cycles.
  - PipeRData = 0xDEADBEEF in the DONE cycle.
  - MemEn asserted exactly once.
- Pipe sw 0x12345678 to 0x20: MemEn=MemWe=1 in c1 with addr 0x20 and data 0x12345678; PipeStall high in c0 and c1 only.
- LdReq held while pipe requests every cycle, STARVE_MAX=4:
  - LdGnt in the 5th contested IDLE cycle.
  - PipeStall stays high through the loader transaction.
  - starve_cnt returns to 0.
- Loader read 0x40 returning 0xA5A5A5A5: LdGnt c0, one-cycle LdRValid in c4 with LdRData = 0xA5A5A5A5.
- Rst pulled low during WAIT of a loader read:
  - State IDLE and all outputs at reset values.
  - No LdRValid after release.
  - A new PipeReq completes normally.
- Simultaneous LdReq and PipeReq with starve_cnt=0: pipe served first, loader granted in the next IDLE cycle if the pipe has no new request.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } stateT;

   localparam logic OWNER_PIPE = 1'b0;
   localparam logic OWNER_LD   = 1'b1;

   localparam int DEF_MEM_LAT    = 2;
   localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of arbitrations the loader has lost in a row.
module mem_arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX,
   parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             inc,
   input  logic             clr,
   output logic             hit,
   output logic [CNT_W-1:0] cnt
);

   assign hit = (cnt == CNT_W'(STARVE_MAX));

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !hit) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported data memory shared between the MEM stage and the loader/debug port,
// one transaction at a time through IDLE -> ISSUE -> (WAIT) -> DONE.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = DEF_MEM_LAT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic                             Clk,
   input  logic                             Rst,
   input  logic                             PipeReq,
   input  logic                             PipeWe,
   input  logic [ADDR_W-1:0]                PipeAddr,
   input  logic [DATA_W-1:0]                PipeWData,
   output logic [DATA_W-1:0]                PipeRData,
   output logic                             PipeStall,
   input  logic                             LdReq,
   input  logic                             LdWe,
   input  logic [ADDR_W-1:0]                LdAddr,
   input  logic [DATA_W-1:0]                LdWData,
   output logic                             LdGnt,
   output logic [DATA_W-1:0]                LdRData,
   output logic                             LdRValid,
   output logic                             MemEn,
   output logic                             MemWe,
   output logic [ADDR_W-1:0]                MemAddr,
   output logic [DATA_W-1:0]                MemWData,
   input  logic [DATA_W-1:0]                MemRData,
   output stateT                            DbgState,
   output logic [$clog2(STARVE_MAX+1)-1:0]  DbgStarveCnt
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam int LAT_W = $clog2(MEM_LAT + 1);

   stateT             state;
   logic              owner;
   logic              latWe;
   logic [ADDR_W-1:0] latAddr;
   logic [DATA_W-1:0] latWData;
   logic [DATA_W-1:0] rdReg;
   logic [LAT_W-1:0]  waitCnt;
   logic              memEnQ;
   logic              memWeQ;
   logic              ldRValidQ;

   logic             starveHit;
   logic [CNT_W-1:0] starveCnt;
   logic             ldWins;
   logic             pipeWins;
   logic             inIdle;

   // Loader handshake: LdReq is a level held until LdGnt; LdGnt is a one-cycle
   // pulse in the IDLE cycle that accepts the request (never while in reset).
   assign inIdle   = Rst && (state == S_IDLE);
   assign ldWins   = inIdle && LdReq && (!PipeReq || starveHit);
   assign pipeWins = inIdle && PipeReq && !ldWins;

   mem_arb_starve_ctr #(
      .STARVE_MAX(STARVE_MAX),
      .CNT_W     (CNT_W)
   ) uStarve (
      .Clk(Clk),
      .Rst(Rst),
      .inc(pipeWins && LdReq),
      .clr(ldWins),
      .hit(starveHit),
      .cnt(starveCnt)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state     <= S_IDLE;
         owner     <= OWNER_PIPE;
         latWe     <= 1'b0;
         latAddr   <= '0;
         latWData  <= '0;
         rdReg     <= '0;
         waitCnt   <= '0;
         memEnQ    <= 1'b0;
         memWeQ    <= 1'b0;
         ldRValidQ <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ldWins) begin
                  owner    <= OWNER_LD;
                  latWe    <= LdWe;
                  latAddr  <= LdAddr;
                  latWData <= LdWData;
                  memEnQ   <= 1'b1;
                  memWeQ   <= LdWe;
                  state    <= S_ISSUE;
               end else if (pipeWins) begin
                  owner    <= OWNER_PIPE;
                  latWe    <= PipeWe;
                  latAddr  <= PipeAddr;
                  latWData <= PipeWData;
                  memEnQ   <= 1'b1;
                  memWeQ   <= PipeWe;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               memEnQ  <= 1'b0;
               memWeQ  <= 1'b0;
               waitCnt <= LAT_W'(MEM_LAT - 1);
               state   <= latWe ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
               // Data is sampled on the edge that closes the last latency cycle.
               if (waitCnt == '0) begin
                  rdReg     <= MemRData;
                  ldRValidQ <= (owner == OWNER_LD);
                  state     <= S_DONE;
               end else begin
                  waitCnt <= waitCnt - 1'b1;
               end
            end
            S_DONE: begin
               ldRValidQ <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign PipeStall    = PipeReq && !((state == S_DONE) && (owner == OWNER_PIPE));
   assign PipeRData    = rdReg;
   assign LdRData      = rdReg;
   assign LdGnt        = ldWins;
   assign LdRValid     = ldRValidQ;
   assign MemEn        = memEnQ;
   assign MemWe        = memWeQ;
   assign MemAddr      = latAddr;
   assign MemWData     = latWData;
   assign DbgState     = state;
   assign DbgStarveCnt = starveCnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios for mem_port_arbiter with hand-computed cycle expectations.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        PipeReq = 1'b0;
   logic        PipeWe = 1'b0;
   logic [31:0] PipeAddr = '0;
   logic [31:0] PipeWData = '0;
   logic [31:0] PipeRData;
   logic        PipeStall;
   logic        LdReq = 1'b0;
   logic        LdWe = 1'b0;
   logic [31:0] LdAddr = '0;
   logic [31:0] LdWData = '0;
   logic        LdGnt;
   logic [31:0] LdRData;
   logic        LdRValid;
   logic        MemEn;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData = '0;
   stateT       DbgState;
   logic [2:0]  DbgStarveCnt;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
      .Clk(Clk), .Rst(Rst),
      .PipeReq(PipeReq), .PipeWe(PipeWe), .PipeAddr(PipeAddr), .PipeWData(PipeWData),
      .PipeRData(PipeRData), .PipeStall(PipeStall),
      .LdReq(LdReq), .LdWe(LdWe), .LdAddr(LdAddr), .LdWData(LdWData),
      .LdGnt(LdGnt), .LdRData(LdRData), .LdRValid(LdRValid),
      .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
      .MemRData(MemRData), .DbgState(DbgState), .DbgStarveCnt(DbgStarveCnt)
   );

   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      @(negedge Clk);
   endtask

   task automatic test_reset();
      settle();
      checks++; if (DbgState !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", DbgState, S_IDLE); end
      checks++; if (MemEn !== 1'b0 || MemWe !== 1'b0) begin errors++; $display("FAIL reset_mem: got en=%b we=%b want 0 0", MemEn, MemWe); end
      checks++; if (LdGnt !== 1'b0 || LdRValid !== 1'b0) begin errors++; $display("FAIL reset_ld: got gnt=%b rv=%b want 0 0", LdGnt, LdRValid); end
      checks++; if (PipeStall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b want 0", PipeStall); end
      checks++; if (PipeRData !== 32'h0 || MemAddr !== 32'h0 || MemWData !== 32'h0) begin errors++; $display("FAIL reset_regs: got rd=%h addr=%h wd=%h want 0", PipeRData, MemAddr, MemWData); end
      checks++; if (DbgStarveCnt !== 3'd0) begin errors++; $display("FAIL reset_starve: got %0d want 0", DbgStarveCnt); end
      PipeReq = 1'b1;
      LdReq   = 1'b1;
      #1;
      checks++; if (PipeStall !== 1'b1) begin errors++; $display("FAIL reset_stall_req: got %b want 1", PipeStall); end
      checks++; if (LdGnt !== 1'b0) begin errors++; $display("FAIL reset_gnt_req: got %b want 0", LdGnt); end
      PipeReq = 1'b0;
      LdReq   = 1'b0;
      next_cycle();
      Rst = 1'b1;
      next_cycle();
   endtask

   task automatic test_pipe_read(input logic [31:0] addr, input logic [31:0] data);
      logic [4:0] expStall;
      logic [4:0] expEn;
      int enCount;
      expStall = 5'b01111;
      expEn    = 5'b00010;
      enCount  = 0;
      PipeReq  = 1'b1;
      PipeWe   = 1'b0;
      PipeAddr = addr;
      for (int c = 0; c < 5; c++) begin
         MemRData = (c == 3) ? data : 32'h0;
         settle();
         checks++; if (PipeStall !== expStall[c]) begin errors++; $display("FAIL prd_stall c%0d: got %b want %b", c, PipeStall, expStall[c]); end
         checks++; if (MemEn !== expEn[c]) begin errors++; $display("FAIL prd_en c%0d: got %b want %b", c, MemEn, expEn[c]); end
         if (MemEn === 1'b1) enCount++;
         if (c == 1) begin
            checks++; if (MemAddr !== addr || MemWe !== 1'b0) begin errors++; $display("FAIL prd_issue: got addr=%h we=%b want %h 0", MemAddr, MemWe, addr); end
         end
         if (c == 4) begin
            checks++; if (PipeRData !== data) begin errors++; $display("FAIL prd_data: got %h want %h", PipeRData, data); end
            checks++; if (DbgState !== S_DONE) begin errors++; $display("FAIL prd_done: got %0d want %0d", DbgState, S_DONE); end
         end
         next_cycle();
      end
      PipeReq  = 1'b0;
      MemRData = 32'h0;
      settle();
      checks++; if (enCount !== 1) begin errors++; $display("FAIL prd_en_count: got %0d want 1", enCount); end
      checks++; if (DbgState !== S_IDLE || PipeRData !== data) begin errors++; $display("FAIL prd_after: got st=%0d rd=%h want %0d %h", DbgState, PipeRData, S_IDLE, data); end
      next_cycle();
   endtask

   task automatic test_pipe_write(input logic [31:0] prevRead);
      logic [2:0] expStall;
      expStall  = 3'b011;
      PipeReq   = 1'b1;
      PipeWe    = 1'b1;
      PipeAddr  = 32'h20;
      PipeWData = 32'h12345678;
      for (int c = 0; c < 3; c++) begin
         settle();
         checks++; if (PipeStall !== expStall[c]) begin errors++; $display("FAIL pwr_stall c%0d: got %b want %b", c, PipeStall, expStall[c]); end
         if (c == 1) begin
            checks++; if (MemEn !== 1'b1 || MemWe !== 1'b1) begin errors++; $display("FAIL pwr_strobe: got en=%b we=%b want 1 1", MemEn, MemWe); end
            checks++; if (MemAddr !== 32'h20 || MemWData !== 32'h12345678) begin errors++; $display("FAIL pwr_bus: got addr=%h wd=%h want 00000020 12345678", MemAddr, MemWData); end
         end else begin
            checks++; if (MemEn !== 1'b0) begin errors++; $display("FAIL pwr_en_off c%0d: got %b want 0", c, MemEn); end
         end
         next_cycle();
      end
      PipeReq = 1'b0;
      PipeWe  = 1'b0;
      settle();
      checks++; if (DbgState !== S_IDLE) begin errors++; $display("FAIL pwr_idle: got %0d want %0d", DbgState, S_IDLE); end
      checks++; if (PipeRData !== prevRead) begin errors++; $display("FAIL pwr_rd_hold: got %h want %h", PipeRData, prevRead); end
      next_cycle();
   endtask

   task automatic test_loader_read();
      logic [5:0] expGnt;
      logic [5:0] expRv;
      expGnt = 6'b000001;
      expRv  = 6'b010000;
      LdReq  = 1'b1;
      LdWe   = 1'b0;
      LdAddr = 32'h40;
      for (int c = 0; c < 6; c++) begin
         MemRData = (c == 3) ? 32'hA5A5A5A5 : 32'h0;
         settle();
         checks++; if (LdGnt !== expGnt[c]) begin errors++; $display("FAIL ldr_gnt c%0d: got %b want %b", c, LdGnt, expGnt[c]); end
         checks++; if (LdRValid !== expRv[c]) begin errors++; $display("FAIL ldr_rvalid c%0d: got %b want %b", c, LdRValid, expRv[c]); end
         if (c == 1) begin
            checks++; if (MemEn !== 1'b1 || MemWe !== 1'b0 || MemAddr !== 32'h40) begin errors++; $display("FAIL ldr_issue: got en=%b we=%b addr=%h want 1 0 00000040", MemEn, MemWe, MemAddr); end
         end
         if (c == 4) begin
            checks++; if (LdRData !== 32'hA5A5A5A5) begin errors++; $display("FAIL ldr_data: got %h want a5a5a5a5", LdRData); end
         end
         next_cycle();
         if (c == 0) LdReq = 1'b0;
      end
      MemRData = 32'h0;
   endtask

   task automatic test_starvation();
      int contested;
      int gntCycle;
      contested = 0;
      gntCycle  = -1;
      PipeReq   = 1'b1;
      PipeWe    = 1'b1;
      PipeAddr  = 32'h100;
      PipeWData = 32'h55;
      LdReq     = 1'b1;
      LdWe      = 1'b1;
      LdAddr    = 32'h80;
      LdWData   = 32'hCAFEF00D;
      for (int c = 0; c < 40; c++) begin
         settle();
         if (DbgState == S_IDLE && LdReq && PipeReq) contested++;
         if (LdGnt === 1'b1) begin
            gntCycle = c;
            checks++; if (DbgStarveCnt !== 3'd4) begin errors++; $display("FAIL stv_cnt_full: got %0d want 4", DbgStarveCnt); end
            break;
         end
         next_cycle();
      end
      checks++; if (gntCycle !== 12) begin errors++; $display("FAIL stv_gnt_cycle: got %0d want 12", gntCycle); end
      checks++; if (contested !== 5) begin errors++; $display("FAIL stv_contested: got %0d want 5", contested); end
      next_cycle();
      LdReq = 1'b0;
      settle();
      checks++; if (MemEn !== 1'b1 || MemWe !== 1'b1) begin errors++; $display("FAIL stv_issue: got en=%b we=%b want 1 1", MemEn, MemWe); end
      checks++; if (MemAddr !== 32'h80 || MemWData !== 32'hCAFEF00D) begin errors++; $display("FAIL stv_bus: got addr=%h wd=%h want 00000080 cafef00d", MemAddr, MemWData); end
      checks++; if (PipeStall !== 1'b1) begin errors++; $display("FAIL stv_stall_issue: got %b want 1", PipeStall); end
      checks++; if (DbgStarveCnt !== 3'd0) begin errors++; $display("FAIL stv_cnt_clr: got %0d want 0", DbgStarveCnt); end
      next_cycle();
      settle();
      checks++; if (DbgState !== S_DONE || PipeStall !== 1'b1) begin errors++; $display("FAIL stv_done: got st=%0d stall=%b want %0d 1", DbgState, PipeStall, S_DONE); end
      checks++; if (LdRValid !== 1'b0) begin errors++; $display("FAIL stv_no_rvalid: got %b want 0", LdRValid); end
      next_cycle();
      PipeReq = 1'b0;
      PipeWe  = 1'b0;
      settle();
      checks++; if (DbgState !== S_IDLE) begin errors++; $display("FAIL stv_idle: got %0d want %0d", DbgState, S_IDLE); end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      int rvCount;
      rvCount = 0;
      LdReq   = 1'b1;
      LdWe    = 1'b0;
      LdAddr  = 32'h60;
      settle();
      checks++; if (LdGnt !== 1'b1) begin errors++; $display("FAIL rst_gnt: got %b want 1", LdGnt); end
      next_cycle();
      LdReq = 1'b0;
      next_cycle();
      MemRData = 32'h11111111;
      settle();
      checks++; if (DbgState !== S_WAIT) begin errors++; $display("FAIL rst_in_wait: got %0d want %0d", DbgState, S_WAIT); end
      Rst = 1'b0;
      #1;
      checks++; if (DbgState !== S_IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d want %0d", DbgState, S_IDLE); end
      checks++; if (MemEn !== 1'b0 || MemWe !== 1'b0 || LdGnt !== 1'b0 || LdRValid !== 1'b0) begin errors++; $display("FAIL rst_mid_outs: got en=%b we=%b gnt=%b rv=%b want 0 0 0 0", MemEn, MemWe, LdGnt, LdRValid); end
      checks++; if (LdRData !== 32'h0 || MemAddr !== 32'h0) begin errors++; $display("FAIL rst_mid_regs: got rd=%h addr=%h want 0 0", LdRData, MemAddr); end
      checks++; if (PipeStall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall0: got %b want 0", PipeStall); end
      PipeReq = 1'b1;
      #1;
      checks++; if (PipeStall !== 1'b1) begin errors++; $display("FAIL rst_mid_stall1: got %b want 1", PipeStall); end
      PipeReq = 1'b0;
      next_cycle();
      next_cycle();
      Rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         settle();
         if (LdRValid === 1'b1) rvCount++;
         next_cycle();
      end
      checks++; if (rvCount !== 0) begin errors++; $display("FAIL rst_no_rvalid: got %0d pulses want 0", rvCount); end
      MemRData = 32'h0;
   endtask

   task automatic test_simultaneous();
      PipeReq   = 1'b1;
      PipeWe    = 1'b1;
      PipeAddr  = 32'h30;
      PipeWData = 32'h0A0A0A0A;
      LdReq     = 1'b1;
      LdWe      = 1'b1;
      LdAddr    = 32'h44;
      LdWData   = 32'h44444444;
      settle();
      checks++; if (LdGnt !== 1'b0 || PipeStall !== 1'b1) begin errors++; $display("FAIL sim_c0: got gnt=%b stall=%b want 0 1", LdGnt, PipeStall); end
      checks++; if (DbgStarveCnt !== 3'd0) begin errors++; $display("FAIL sim_cnt0: got %0d want 0", DbgStarveCnt); end
      next_cycle();
      settle();
      checks++; if (MemEn !== 1'b1 || MemAddr !== 32'h30 || MemWData !== 32'h0A0A0A0A) begin errors++; $display("FAIL sim_pipe_issue: got en=%b addr=%h wd=%h want 1 00000030 0a0a0a0a", MemEn, MemAddr, MemWData); end
      checks++; if (DbgStarveCnt !== 3'd1) begin errors++; $display("FAIL sim_cnt1: got %0d want 1", DbgStarveCnt); end
      next_cycle();
      settle();
      checks++; if (PipeStall !== 1'b0 || LdGnt !== 1'b0) begin errors++; $display("FAIL sim_pipe_done: got stall=%b gnt=%b want 0 0", PipeStall, LdGnt); end
      next_cycle();
      PipeReq = 1'b0;
      PipeWe  = 1'b0;
      settle();
      checks++; if (LdGnt !== 1'b1) begin errors++; $display("FAIL sim_ld_gnt: got %b want 1", LdGnt); end
      next_cycle();
      LdReq = 1'b0;
      settle();
      checks++; if (MemEn !== 1'b1 || MemWe !== 1'b1 || MemAddr !== 32'h44 || MemWData !== 32'h44444444) begin errors++; $display("FAIL sim_ld_issue: got en=%b we=%b addr=%h wd=%h want 1 1 00000044 44444444", MemEn, MemWe, MemAddr, MemWData); end
      checks++; if (DbgStarveCnt !== 3'd0) begin errors++; $display("FAIL sim_cnt_clr: got %0d want 0", DbgStarveCnt); end
      next_cycle();
      settle();
      checks++; if (DbgState !== S_DONE || LdRValid !== 1'b0) begin errors++; $display("FAIL sim_ld_done: got st=%0d rv=%b want %0d 0", DbgState, LdRValid, S_DONE); end
      next_cycle();
      settle();
      checks++; if (DbgState !== S_IDLE) begin errors++; $display("FAIL sim_idle: got %0d want %0d", DbgState, S_IDLE); end
      next_cycle();
   endtask

   initial begin
      #1;
      test_reset();
      test_pipe_read(32'h10, 32'hDEADBEEF);
      test_pipe_write(32'hDEADBEEF);
      test_loader_read();
      test_starvation();
      test_reset_mid();
      test_pipe_read(32'h14, 32'h0BADCAFE);
      test_simultaneous();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
